reg_file_rd2w1: RTL and testbench
=================================

Name: reg_file_rd2w1

Overview:
- 8 x 16-bit general-purpose register file for the 16-bit RISC core.
- One synchronous write port (write-back stage) and two registered read ports (operand fetch for decode/execute).
- It is the read side of the core's edge-triggered storage. Read data appears one cycle after the request. Same-cycle write-to-read bypass means operand fetch never sees stale data.
- R0 is hardwired to zero.

Parameters:
- DATA_W, 16, register and data width in bits.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- ra_en  input  1  read request, port A.
- ra_addr  input  ADDR_W  read index, port A.
- ra_data  output  DATA_W  registered read data, port A.
- ra_valid  output  1  high the cycle after an accepted port-A request.
- rb_en  input  1  read request, port B.
- rb_addr  input  ADDR_W  read index, port B.
- rb_data  output  DATA_W  registered read data, port B.
- rb_valid  output  1  high the cycle after an accepted port-B request.

Behaviour:
- Reset: rst_n low clears all registers, ra_data, rb_data, ra_valid and rb_valid to 0 immediately, without waiting for clk. Release is synchronous to the next posedge.
- Reset mid-operation: in-flight reads and writes are discarded, and the valid outputs drop at once.
- Write: at posedge with we=1 and waddr!=0, regs[waddr] <= wdata. A write to R0 is silently ignored.
- Read latency is 1 cycle. At posedge with rX_en=1:
  - rX_data <= value of regs[rX_addr] as updated by any same-cycle write;
  - rX_valid <= 1.
- Read idle: at posedge with rX_en=0, rX_valid <= 0 and rX_data holds its previous value.
- Bypass rule: if we=1, waddr==rX_addr and waddr!=0 on the same edge, rX_data takes wdata (write-first).
- R0: a read of R0 always returns 16'h0000, even if written the same cycle.
- Ports A and B are fully independent. Both may read the same address on the same edge, and both get identical data.
- No back-pressure: every request is accepted, and a new request may be issued every cycle (throughput 1 read per port per cycle).
- No X propagation: unwritten registers read as 0 after reset.
- Address width is exact, so there are no out-of-range indices.
- Data is stored unsigned with no arithmetic; DATA_W bits are passed through unmodified.

Decomposition:
- Shared package: DATA_W, ADDR_W, NUM_REGS, ZERO_REG index (0), and the reg_t / raddr_t typedefs; the core's decode and write-back stages reuse them.
- Sub-module reg_cell:
  - one DATA_W-wide edge-triggered register with load enable and async active-low clear;
  - instantiated NUM_REGS-1 times (R1..R7) for storage;
  - instantiated once per read-data output register.
- Top level contains the write decode, the read muxes, bypass compare and valid flops.

Test Plan:
- Reset: hold rst_n=0 mid-clock with prior nonzero state -> ra_data=rb_data=0 and ra_valid=rb_valid=0 asynchronously; after release, reading R1..R7 returns 16'h0000.
- Basic write/read: write R3=16'hA5C3. Next edge ra_en=1, ra_addr=3 -> one cycle later ra_data=16'hA5C3, ra_valid=1. The following edge with ra_en=0 -> ra_valid=0, ra_data holds A5C3.
- Bypass: same edge we=1, waddr=5, wdata=16'h1234, rb_en=1, rb_addr=5 -> next cycle rb_data=16'h1234.
- R0: write R0=16'hFFFF while ra_en=1, ra_addr=0 -> ra_data=16'h0000. A later read of R0 is also 16'h0000.
- Dual port: R2=16'h00FF, R7=16'hBEEF; A reads 2 and B reads 7 on the same edge -> 16'h00FF and 16'hBEEF. Both ports reading 7 -> both 16'hBEEF.
- Back-to-back: port A reads R1..R7 on consecutive cycles after writing R_i=16'h1111*i -> ra_valid high 7 consecutive cycles with data 1111, 2222, …, 7777 in order.

Source files
------------

// File: rtl/reg_file_rd2w1_pkg.sv
// Shared register-file definitions for the 16-bit RISC core.
// Decode and write-back stages reuse these widths and typedefs.
package reg_file_rd2w1_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int ZERO_REG = 0;

    typedef logic [DATA_W-1:0] reg_t;
    typedef logic [ADDR_W-1:0] raddr_t;

    // True when a same-edge write must be forwarded to a read of readAddr.
    // R0 never forwards because it is hardwired to zero.
    function automatic logic isBypass(input logic writeEn, input raddr_t writeAddr,
                                      input raddr_t readAddr);
        return writeEn && (writeAddr == readAddr) && (writeAddr != raddr_t'(ZERO_REG));
    endfunction

endpackage

// File: rtl/reg_file_rd2w1_reg_cell.sv
// One DATA_W-wide storage register with load enable and async active-low clear.
// Used for every architectural register (R1..R7) and for each read-data output.
module reg_cell
    import reg_file_rd2w1_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Load on enable, otherwise hold; reset clears without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_file_rd2w1.sv
// 8 x 16-bit register file: one write port, two registered read ports with
// write-first bypass. R0 reads as zero and ignores writes.
module reg_file_rd2w1
    import reg_file_rd2w1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ra_en,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_valid,
    input  logic              rb_en,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid
);

    reg_t store_q [NUM_REGS];
    reg_t ra_data_d;
    reg_t rb_data_d;
    logic ra_valid_q;
    logic rb_valid_q;

    // R0 has no storage; it is a constant zero.
    assign store_q[ZERO_REG] = '0;

    // Storage cells for R1..R7, each loaded only when the write decodes to it.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
        logic cellWe;
        assign cellWe = we && (waddr == raddr_t'(i));

        reg_cell #(.W(DATA_W)) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .en_i (cellWe),
            .d_i  (wdata),
            .q_o  (store_q[i])
        );
    end

    // Port A read mux: zero for R0, forwarded write data on a hit, else storage.
    always_comb begin
        ra_data_d = store_q[ra_addr];
        if (ra_addr == raddr_t'(ZERO_REG)) begin
            ra_data_d = '0;
        end else if (isBypass(we, waddr, ra_addr)) begin
            ra_data_d = wdata;
        end
    end

    // Port B read mux: same selection rules as port A, fully independent.
    always_comb begin
        rb_data_d = store_q[rb_addr];
        if (rb_addr == raddr_t'(ZERO_REG)) begin
            rb_data_d = '0;
        end else if (isBypass(we, waddr, rb_addr)) begin
            rb_data_d = wdata;
        end
    end

    // Read-data output registers only load on a request, so idle cycles hold.
    reg_cell #(.W(DATA_W)) u_ra_data (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (ra_en),
        .d_i  (ra_data_d),
        .q_o  (ra_data)
    );

    reg_cell #(.W(DATA_W)) u_rb_data (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (rb_en),
        .d_i  (rb_data_d),
        .q_o  (rb_data)
    );

    // Valid flags mark the cycle after an accepted request and drop at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_valid_q <= 1'b0;
            rb_valid_q <= 1'b0;
        end else begin
            ra_valid_q <= ra_en;
            rb_valid_q <= rb_en;
        end
    end

    assign ra_valid = ra_valid_q;
    assign rb_valid = rb_valid_q;

endmodule

// File: tb/tb_reg_file_rd2w1.sv
// Directed testbench for reg_file_rd2w1 with hand-computed expected values.
module tb_reg_file_rd2w1;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        ra_en;
    logic [2:0]  ra_addr;
    logic [15:0] ra_data;
    logic        ra_valid;
    logic        rb_en;
    logic [2:0]  rb_addr;
    logic [15:0] rb_data;
    logic        rb_valid;

    int checkCount;
    int passCount;

    reg_file_rd2w1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .ra_en   (ra_en),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .ra_valid(ra_valid),
        .rb_en   (rb_en),
        .rb_addr (rb_addr),
        .rb_data (rb_data),
        .rb_valid(rb_valid)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and return 1 ns after the edge.
    task automatic applyStimulus(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic ae, input logic [2:0] aa,
                                 input logic be, input logic [2:0] ba);
        we = w; waddr = wa; wdata = wd;
        ra_en = ae; ra_addr = aa;
        rb_en = be; rb_addr = ba;
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        logic [15:0] expVal;
        checkCount = 0;
        passCount  = 0;
        rst_n = 1'b0;
        we = 0; waddr = 0; wdata = 0;
        ra_en = 0; ra_addr = 0; rb_en = 0; rb_addr = 0;
        #12 rst_n = 1'b1;

        // Build nonzero state then assert reset between edges.
        applyStimulus(1, 3'd1, 16'hDEAD, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3'd1, 1, 3'd1);
        checkOutput("pre_reset_ra_data", ra_data, 16'hDEAD);
        checkOutput("pre_reset_rb_valid", {15'b0, rb_valid}, 16'h0001);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ra_data", ra_data, 16'h0000);
        checkOutput("async_reset_rb_data", rb_data, 16'h0000);
        checkOutput("async_reset_ra_valid", {15'b0, ra_valid}, 16'h0000);
        checkOutput("async_reset_rb_valid", {15'b0, rb_valid}, 16'h0000);
        #2 rst_n = 1'b1;

        // All storage reads zero after reset.
        for (int i = 1; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1, 3'(i), 1, 3'(8 - i));
            checkOutput($sformatf("reset_ra_R%0d", i), ra_data, 16'h0000);
            checkOutput($sformatf("reset_rb_R%0d", 8 - i), rb_data, 16'h0000);
        end

        // Basic write then read, then idle hold.
        applyStimulus(1, 3'd3, 16'hA5C3, 0, 0, 0, 0);
        checkOutput("no_req_ra_valid", {15'b0, ra_valid}, 16'h0000);
        applyStimulus(0, 0, 0, 1, 3'd3, 0, 0);
        checkOutput("basic_ra_data", ra_data, 16'hA5C3);
        checkOutput("basic_ra_valid", {15'b0, ra_valid}, 16'h0001);
        checkOutput("basic_rb_idle_valid", {15'b0, rb_valid}, 16'h0000);
        applyStimulus(0, 0, 0, 0, 3'd5, 0, 0);
        checkOutput("idle_ra_valid", {15'b0, ra_valid}, 16'h0000);
        checkOutput("idle_ra_hold", ra_data, 16'hA5C3);

        // Write-first bypass on port B; port A reads R5's old value is not requested.
        applyStimulus(1, 3'd5, 16'h1234, 0, 0, 1, 3'd5);
        checkOutput("bypass_rb_data", rb_data, 16'h1234);
        checkOutput("bypass_rb_valid", {15'b0, rb_valid}, 16'h0001);
        applyStimulus(0, 0, 0, 1, 3'd5, 0, 0);
        checkOutput("bypass_stored_R5", ra_data, 16'h1234);

        // R0 ignores writes and reads zero even with a same-edge write.
        applyStimulus(1, 3'd0, 16'hFFFF, 1, 3'd0, 0, 0);
        checkOutput("r0_bypass_ra_data", ra_data, 16'h0000);
        applyStimulus(0, 0, 0, 1, 3'd3, 0, 0);
        checkOutput("r0_prep_ra_data", ra_data, 16'hA5C3);
        applyStimulus(0, 0, 0, 1, 3'd0, 1, 3'd0);
        checkOutput("r0_later_ra_data", ra_data, 16'h0000);
        checkOutput("r0_later_rb_data", rb_data, 16'h0000);

        // Dual port: different and identical addresses on the same edge.
        applyStimulus(1, 3'd2, 16'h00FF, 0, 0, 0, 0);
        applyStimulus(1, 3'd7, 16'hBEEF, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3'd2, 1, 3'd7);
        checkOutput("dual_ra_R2", ra_data, 16'h00FF);
        checkOutput("dual_rb_R7", rb_data, 16'hBEEF);
        applyStimulus(0, 0, 0, 1, 3'd7, 1, 3'd7);
        checkOutput("same_ra_R7", ra_data, 16'hBEEF);
        checkOutput("same_rb_R7", rb_data, 16'hBEEF);

        // Back-to-back reads of R1..R7 after writing R_i = 16'h1111 * i.
        for (int i = 1; i < 8; i++) begin
            expVal = 16'h1111 * 16'(i);
            applyStimulus(1, 3'(i), expVal, 0, 0, 0, 0);
        end
        for (int i = 1; i < 8; i++) begin
            expVal = 16'h1111 * 16'(i);
            applyStimulus(0, 0, 0, 1, 3'(i), 0, 0);
            checkOutput($sformatf("b2b_valid_R%0d", i), {15'b0, ra_valid}, 16'h0001);
            checkOutput($sformatf("b2b_data_R%0d", i), ra_data, expVal);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_end_valid", {15'b0, ra_valid}, 16'h0000);
        checkOutput("b2b_end_hold", ra_data, 16'h7777);

        // Reset mid-operation discards storage and drops valid immediately.
        we = 1; waddr = 3'd4; wdata = 16'h5555; ra_en = 1; ra_addr = 3'd4;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_ra_valid", {15'b0, ra_valid}, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("mid_reset_held_ra_data", ra_data, 16'h0000);
        #2 rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 3'd7, 1, 3'd4);
        checkOutput("post_reset_R7", ra_data, 16'h0000);
        checkOutput("post_reset_R4", rb_data, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
